// File: rtl/multi_ctrl_pkg.sv
// rtl/multi_ctrl_pkg.sv - shared opcode, funct, ALU-op and state encodings for multi_ctrl
package multi_ctrl_pkg;

  // FSM states; held in a raw 3-bit register so encodings 5-7 stay representable
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLL  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_SRA  = 4'd11,
    ALU_SLTR = 4'd12
  } alu_op_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct codes (IR[5:0]) for R-type
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // I-type instructions that compute in the ALU and write back through sWB
  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/alu_funct_dec.sv
// rtl/alu_funct_dec.sv - combinational R-type Funct to ALU-op decoder
module alu_funct_dec
  import multi_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output alu_op_e    alu_op_o,
  output logic       shamt_o,   // operand A comes from the shamt field
  output logic       valid_o    // funct is a recognised R-type (jr included)
);

  // Map funct to the ALU operation; jr is legal but uses no ALU op
  always_comb begin
    alu_op_o = ALU_NOP;
    shamt_o  = 1'b0;
    valid_o  = 1'b1;
    case (funct_i)
      FN_ADD, FN_ADDU: alu_op_o = ALU_ADD;
      FN_SUB, FN_SUBU: alu_op_o = ALU_SUB;
      FN_AND:          alu_op_o = ALU_AND;
      FN_OR:           alu_op_o = ALU_OR;
      FN_XOR:          alu_op_o = ALU_XOR;
      FN_NOR:          alu_op_o = ALU_NOR;
      FN_SLT:          alu_op_o = ALU_SLT;
      FN_SLTU:         alu_op_o = ALU_SLTU;
      FN_SLL: begin alu_op_o = ALU_SLL; shamt_o = 1'b1; end
      FN_SRL: begin alu_op_o = ALU_SRL; shamt_o = 1'b1; end
      FN_SRA: begin alu_op_o = ALU_SRA; shamt_o = 1'b1; end
      FN_SLLV:         alu_op_o = ALU_SLL;
      FN_SRLV:         alu_op_o = ALU_SRL;
      FN_SRAV:         alu_op_o = ALU_SRA;
      FN_JR:           alu_op_o = ALU_NOP;
      default:         valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_ctrl.sv
// rtl/multi_ctrl.sv - multi-cycle IF/ID/EXE/MEM/WB control unit for the M_CPU datapath
module multi_ctrl
  import multi_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       EXTOp,
  output logic [1:0] PCSrc,
  output logic [3:0] ALUOp,
  output logic [2:0] State
);

  logic [2:0] state_q, state_d;
  alu_op_e    fn_op;
  logic       fn_shamt, fn_valid;
  logic       is_jr;

  // Ungated write enables; reset masks them below so an aborted instruction writes nothing
  logic       pc_write, ir_write, mem_write, reg_write;
  alu_op_e    alu_op;

  alu_funct_dec u_funct_dec (
    .funct_i  (Funct),
    .alu_op_o (fn_op),
    .shamt_o  (fn_shamt),
    .valid_o  (fn_valid)
  );

  assign is_jr = (Op == OP_RTYPE) && (Funct == FN_JR);

  // State register; asynchronous reset returns straight to fetch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Next-state sequencing per instruction class
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (Op == OP_RTYPE)
          state_d = (fn_valid && !is_jr) ? S_EXE : S_IF;
        else if (Op == OP_LW || Op == OP_SW || Op == OP_BEQ || Op == OP_BNE || is_imm_alu(Op))
          state_d = S_EXE;
        else
          state_d = S_IF;   // j, jal and unknown opcodes finish here
      end
      S_EXE: begin
        if (Op == OP_LW || Op == OP_SW)        state_d = S_MEM;
        else if (Op == OP_BEQ || Op == OP_BNE) state_d = S_IF;
        else                                   state_d = S_WB;
      end
      S_MEM: state_d = (Op == OP_LW) ? S_WB : S_IF;
      S_WB:  state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Datapath controls decoded from state, opcode, funct and Zero
  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    IorD      = 1'b0;
    RegDst    = 2'd0;
    WDSel     = 2'd0;
    ALUSrcA   = 2'd0;
    ALUSrcB   = 2'd0;
    EXTOp     = 1'b0;
    PCSrc     = 2'd0;
    alu_op    = ALU_NOP;
    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        ALUSrcB  = 2'd1;
        alu_op   = ALU_ADD;
        pc_write = 1'b1;
      end
      S_ID: begin
        // PC + (imm<<2) lands in ALUOut for a later branch
        ALUSrcB = 2'd3;
        EXTOp   = 1'b1;
        alu_op  = ALU_ADD;
        if (Op == OP_J) begin
          PCSrc    = 2'd2;
          pc_write = 1'b1;
        end else if (Op == OP_JAL) begin
          PCSrc     = 2'd2;
          pc_write  = 1'b1;
          reg_write = 1'b1;
          RegDst    = 2'd2;
          WDSel     = 2'd2;
        end else if (is_jr) begin
          PCSrc    = 2'd3;
          pc_write = 1'b1;
        end
      end
      S_EXE: begin
        // Register-immediate forms take operand A from register A
        case (Op)
          OP_RTYPE: begin
            ALUSrcA = fn_shamt ? 2'd2 : 2'd1;
            alu_op  = fn_op;
          end
          OP_ADDI: begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; EXTOp = 1'b1; alu_op = ALU_ADD; end
          OP_SLTI: begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; EXTOp = 1'b1; alu_op = ALU_SLT; end
          OP_ANDI: begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; alu_op = ALU_AND; end
          OP_ORI:  begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; alu_op = ALU_OR;  end
          OP_XORI: begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; alu_op = ALU_XOR; end
          OP_LUI:  begin ALUSrcA = 2'd3; ALUSrcB = 2'd2; alu_op = ALU_SLL; end
          OP_LW, OP_SW: begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; EXTOp = 1'b1; alu_op = ALU_ADD; end
          OP_BEQ, OP_BNE: begin
            ALUSrcA  = 2'd1;
            alu_op   = ALU_SUB;
            PCSrc    = 2'd1;
            pc_write = (Op == OP_BEQ) ? Zero : !Zero;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        IorD      = 1'b1;
        mem_write = (Op == OP_SW);
      end
      S_WB: begin
        if (Op == OP_LW) begin
          reg_write = 1'b1;
          WDSel     = 2'd1;
        end else if (Op == OP_RTYPE) begin
          reg_write = 1'b1;
          RegDst    = 2'd1;
        end else if (is_imm_alu(Op)) begin
          reg_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign PCWrite  = pc_write  & rstn;
  assign IRWrite  = ir_write  & rstn;
  assign MemWrite = mem_write & rstn;
  assign RegWrite = reg_write & rstn;
  assign ALUOp    = alu_op;
  assign State    = state_q;

endmodule

// File: tb/tb_multi_ctrl.sv
// tb/tb_multi_ctrl.sv - scoreboard testbench for multi_ctrl
module tb_multi_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, IorD, EXTOp;
  logic [1:0] RegDst, WDSel, ALUSrcA, ALUSrcB, PCSrc;
  logic [3:0] ALUOp;
  logic [2:0] State;

  int vectors = 0;
  int miscompares = 0;
  logic [22:0] exp_q[$];
  logic [22:0] obs_w;

  multi_ctrl dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IorD(IorD), .RegDst(RegDst), .WDSel(WDSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .EXTOp(EXTOp), .PCSrc(PCSrc), .ALUOp(ALUOp), .State(State)
  );

  always #5 clk = ~clk;

  assign obs_w = {PCWrite, IRWrite, MemWrite, RegWrite, IorD, RegDst, WDSel,
                  ALUSrcA, ALUSrcB, EXTOp, PCSrc, ALUOp, State};

  // Pack one cycle's expected controls in the same order as obs_w
  function automatic logic [22:0] cw(input bit pcw, input bit irw, input bit mw, input bit rw,
                                     input bit iord, input bit [1:0] rdst, input bit [1:0] wds,
                                     input bit [1:0] sa, input bit [1:0] sb, input bit ext,
                                     input bit [1:0] pcs, input bit [3:0] aop, input bit [2:0] st);
    return {pcw, irw, mw, rw, iord, rdst, wds, sa, sb, ext, pcs, aop, st};
  endfunction

  task automatic check_val(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [22:0] w);
    exp_q.push_back(w);
  endtask

  task automatic pop_check(input string tag);
    logic [22:0] w;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got %h want <empty scoreboard>", tag, obs_w);
    end else begin
      w = exp_q.pop_front();
      check_val(tag, obs_w, w);
    end
  endtask

  // Called at a falling edge with the DUT in sIF; checks n cycles
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int n);
    Op = op; Funct = fn; Zero = z;
    for (int i = 0; i < n; i++) begin
      #1;
      pop_check($sformatf("%s_c%0d", tag, i));
      @(negedge clk);
    end
  endtask

  logic [22:0] w_rst, w_if, w_id;

  initial begin
    w_rst = cw(0,0,0,0,0, 0,0, 0,1,0, 0, 1, 0);
    w_if  = cw(1,1,0,0,0, 0,0, 0,1,0, 0, 1, 0);
    w_id  = cw(0,0,0,0,0, 0,0, 0,3,1, 0, 1, 1);

    rstn = 1'b0; Op = 6'h00; Funct = 6'h20; Zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      push(w_rst);
      pop_check($sformatf("reset_%0d", i));
    end
    rstn = 1'b1;

    // add
    push(w_if); push(w_id);
    push(cw(0,0,0,0,0, 0,0, 1,0,0, 0, 1, 2));
    push(cw(0,0,0,1,0, 1,0, 0,0,0, 0, 0, 4));
    run_instr("add", 6'h00, 6'h20, 1'b0, 4);

    // lw
    push(w_if); push(w_id);
    push(cw(0,0,0,0,0, 0,0, 1,2,1, 0, 1, 2));
    push(cw(0,0,0,0,1, 0,0, 0,0,0, 0, 0, 3));
    push(cw(0,0,0,1,0, 0,1, 0,0,0, 0, 0, 4));
    run_instr("lw", 6'h23, 6'h00, 1'b0, 5);

    // sw
    push(w_if); push(w_id);
    push(cw(0,0,0,0,0, 0,0, 1,2,1, 0, 1, 2));
    push(cw(0,0,1,0,1, 0,0, 0,0,0, 0, 0, 3));
    run_instr("sw", 6'h2B, 6'h00, 1'b0, 4);

    // beq taken / not taken, bne taken
    push(w_if); push(w_id);
    push(cw(1,0,0,0,0, 0,0, 1,0,0, 1, 2, 2));
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 3);
    push(w_if); push(w_id);
    push(cw(0,0,0,0,0, 0,0, 1,0,0, 1, 2, 2));
    run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 3);
    push(w_if); push(w_id);
    push(cw(1,0,0,0,0, 0,0, 1,0,0, 1, 2, 2));
    run_instr("bne_z0", 6'h05, 6'h00, 1'b0, 3);

    // jal, j, jr, unknown opcode, unknown funct
    push(w_if); push(cw(1,0,0,1,0, 2,2, 0,3,1, 2, 1, 1));
    run_instr("jal", 6'h03, 6'h00, 1'b0, 2);
    push(w_if); push(cw(1,0,0,0,0, 0,0, 0,3,1, 2, 1, 1));
    run_instr("j", 6'h02, 6'h00, 1'b0, 2);
    push(w_if); push(cw(1,0,0,0,0, 0,0, 0,3,1, 3, 1, 1));
    run_instr("jr", 6'h00, 6'h08, 1'b0, 2);
    push(w_if); push(w_id);
    run_instr("bad_op", 6'h3F, 6'h20, 1'b0, 2);
    push(w_if); push(w_id);
    run_instr("bad_fn", 6'h00, 6'h3F, 1'b0, 2);

    // shifts and other R-type ops
    push(w_if); push(w_id);
    push(cw(0,0,0,0,0, 0,0, 2,0,0, 0, 9, 2));
    push(cw(0,0,0,1,0, 1,0, 0,0,0, 0, 0, 4));
    run_instr("sll", 6'h00, 6'h00, 1'b0, 4);
    push(w_if); push(w_id);
    push(cw(0,0,0,0,0, 0,0, 1,0,0, 0, 11, 2));
    push(cw(0,0,0,1,0, 1,0, 0,0,0, 0, 0, 4));
    run_instr("srav", 6'h00, 6'h07, 1'b0, 4);
    push(w_if); push(w_id);
    push(cw(0,0,0,0,0, 0,0, 1,0,0, 0, 8, 2));
    push(cw(0,0,0,1,0, 1,0, 0,0,0, 0, 0, 4));
    run_instr("nor", 6'h00, 6'h27, 1'b0, 4);

    // I-type ALU ops
    push(w_if); push(w_id);
    push(cw(0,0,0,0,0, 0,0, 3,2,0, 0, 9, 2));
    push(cw(0,0,0,1,0, 0,0, 0,0,0, 0, 0, 4));
    run_instr("lui", 6'h0F, 6'h00, 1'b0, 4);
    push(w_if); push(w_id);
    push(cw(0,0,0,0,0, 0,0, 1,2,0, 0, 4, 2));
    push(cw(0,0,0,1,0, 0,0, 0,0,0, 0, 0, 4));
    run_instr("ori", 6'h0D, 6'h00, 1'b0, 4);
    push(w_if); push(w_id);
    push(cw(0,0,0,0,0, 0,0, 1,2,1, 0, 5, 2));
    push(cw(0,0,0,1,0, 0,0, 0,0,0, 0, 0, 4));
    run_instr("slti", 6'h0A, 6'h00, 1'b0, 4);

    // lui aborted by reset in sEXE: no sWB write afterwards
    push(w_if); push(w_id);
    push(cw(0,0,0,0,0, 0,0, 3,2,0, 0, 9, 2));
    run_instr("lui_abort", 6'h0F, 6'h00, 1'b0, 2);
    #1; pop_check("lui_abort_exe");
    #1 rstn = 1'b0;
    #1; push(w_rst); pop_check("abort_rst_async");
    @(negedge clk); #1;
    push(w_rst); pop_check("abort_rst_hold");
    rstn = 1'b1;
    push(w_if); push(w_id);
    push(cw(0,0,0,0,0, 0,0, 1,0,0, 0, 1, 2));
    push(cw(0,0,0,1,0, 1,0, 0,0,0, 0, 0, 4));
    run_instr("add_after", 6'h00, 6'h20, 1'b0, 4);

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
